// File: rtl/hpm_sample_ctrl.sv
// ============================================================================
// Module   : hpm_sample_ctrl
// Brief    : Periodically scans masked HPM counters over a shared counter port
//            and queues {index, value} samples in a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpm_sample_ctrl #(
    parameter int unsigned MHPMCounterNum = 29,
    parameter int unsigned NumCounters    = MHPMCounterNum,
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned XLEN           = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_en_i,
    input  logic [15:0]            cfg_period_i,
    input  logic [NumCounters-1:0] cfg_mask_i,
    input  logic                   csr_req_i,
    input  logic [11:0]            csr_addr_i,
    input  logic                   csr_we_i,
    input  logic [XLEN-1:0]        csr_wdata_i,
    output logic [XLEN-1:0]        csr_rdata_o,
    output logic                   csr_gnt_o,
    output logic [11:0]            pc_addr_o,
    output logic                   pc_we_o,
    output logic [XLEN-1:0]        pc_wdata_o,
    input  logic [XLEN-1:0]        pc_rdata_i,
    output logic                   smp_valid_o,
    input  logic                   smp_ready_i,
    output logic [4:0]             smp_idx_o,
    output logic [63:0]            smp_data_o,
    output logic [15:0]            drop_cnt_o,
    output logic                   busy_o
);

    localparam logic [11:0] c_addr_lo = 12'hB03;
    localparam logic [11:0] c_addr_hi = 12'hB83;
    localparam int unsigned c_ptr_w   = $clog2(FifoDepth);
    localparam int unsigned c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_fifo_full = c_cnt_w'(FifoDepth);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_fifo_depth
        $error("FifoDepth must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_SCAN_LO = 2'd1,
        ST_SCAN_HI = 2'd2,
        ST_NEXT    = 2'd3
    } state_e;

    state_e                   r_state;
    logic [15:0]              r_timer;
    logic [NumCounters-1:0]   r_mask;
    logic [4:0]               r_k;
    logic                     r_has;
    logic [63:0]              r_value;
    logic [4:0]               r_fifo_idx  [FifoDepth];
    logic [63:0]              r_fifo_data [FifoDepth];
    logic [c_ptr_w-1:0]       r_wptr;
    logic [c_ptr_w-1:0]       r_rptr;
    logic [c_cnt_w-1:0]       r_count;
    logic [15:0]              r_drop;

    logic [15:0]              w_period_m1;
    logic [4:0]               w_first_k;
    logic                     w_first_vld;
    logic [4:0]               w_next_k;
    logic                     w_next_vld;
    logic                     w_pop;
    logic                     w_push_req;
    logic                     w_push;
    logic                     w_drop;

    assign w_period_m1 = (cfg_period_i == 16'd0) ? 16'd0 : cfg_period_i - 16'd1;

    // Lowest live mask bit starts a scan; the next one above r_k continues it.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_k   = '0;
        w_next_vld  = 1'b0;
        w_next_k    = '0;
        for (int i = 0; i < int'(NumCounters); i++) begin
            if (cfg_mask_i[i] && !w_first_vld) begin
                w_first_vld = 1'b1;
                w_first_k   = 5'(i);
            end
            if (r_mask[i] && (5'(i) > r_k) && !w_next_vld) begin
                w_next_vld = 1'b1;
                w_next_k   = 5'(i);
            end
        end
    end

    always_comb begin
        csr_gnt_o   = 1'b0;
        csr_rdata_o = '0;
        pc_we_o     = 1'b0;
        pc_wdata_o  = '0;
        pc_addr_o   = 12'd0;
        if (csr_req_i) begin
            csr_gnt_o   = 1'b1;
            csr_rdata_o = pc_rdata_i;
            pc_we_o     = csr_we_i;
            pc_wdata_o  = csr_wdata_i;
            pc_addr_o   = csr_addr_i;
        end else if (r_state == ST_SCAN_LO) begin
            pc_addr_o = c_addr_lo + {7'd0, r_k};
        end else if (r_state == ST_SCAN_HI) begin
            pc_addr_o = c_addr_hi + {7'd0, r_k};
        end
    end

    assign w_pop      = (r_count != '0) && smp_ready_i;
    assign w_push_req = (r_state == ST_NEXT) && !csr_req_i && cfg_en_i && r_has;
    assign w_push     = w_push_req && ((r_count != c_fifo_full) || w_pop);
    assign w_drop     = w_push_req && (r_count == c_fifo_full) && !w_pop;

    // A granted CSR access freezes the whole scan engine, timer included.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_WAIT;
            r_timer <= '0;
            r_mask  <= '0;
            r_k     <= '0;
            r_has   <= 1'b0;
            r_value <= '0;
        end else if (!csr_req_i) begin
            if (r_state == ST_WAIT) begin
                if (cfg_en_i) begin
                    if (r_timer == 16'd0) begin
                        r_mask  <= cfg_mask_i;
                        r_k     <= w_first_k;
                        r_has   <= w_first_vld;
                        r_state <= w_first_vld ? ST_SCAN_LO : ST_NEXT;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
            end else if (!cfg_en_i) begin
                r_state <= ST_WAIT;
                r_timer <= w_period_m1;
                r_has   <= 1'b0;
            end else if (r_state == ST_SCAN_LO) begin
                r_value[XLEN-1:0] <= pc_rdata_i;
                r_state           <= (XLEN == 32) ? ST_SCAN_HI : ST_NEXT;
            end else if (r_state == ST_SCAN_HI) begin
                r_value[63:32] <= pc_rdata_i[31:0];
                r_state        <= ST_NEXT;
            end else if (w_next_vld) begin
                r_k     <= w_next_k;
                r_state <= ST_SCAN_LO;
            end else begin
                r_state <= ST_WAIT;
                r_timer <= w_period_m1;
                r_has   <= 1'b0;
            end
        end
    end

    // On a full FIFO with a simultaneous pop, the write lands in the slot being vacated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                r_fifo_idx[i]  <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_idx[r_wptr]  <= r_k + 5'd3;
                r_fifo_data[r_wptr] <= r_value;
                r_wptr              <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign smp_valid_o = (r_count != '0);
    assign smp_idx_o   = r_fifo_idx[r_rptr];
    assign smp_data_o  = r_fifo_data[r_rptr];
    assign drop_cnt_o  = r_drop;
    assign busy_o      = (r_state != ST_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_hpm_sample_ctrl.sv
// ============================================================================
// Module   : tb_hpm_sample_ctrl
// Brief    : Randomized scoreboard bench for hpm_sample_ctrl (XLEN=32, 6 counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpm_sample_ctrl;

    localparam int XLEN  = 32;
    localparam int NCNT  = 6;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              cfg_en_i;
    logic [15:0]       cfg_period_i;
    logic [NCNT-1:0]   cfg_mask_i;
    logic              csr_req_i;
    logic [11:0]       csr_addr_i;
    logic              csr_we_i;
    logic [XLEN-1:0]   csr_wdata_i;
    logic [XLEN-1:0]   csr_rdata_o;
    logic              csr_gnt_o;
    logic [11:0]       pc_addr_o;
    logic              pc_we_o;
    logic [XLEN-1:0]   pc_wdata_o;
    logic [XLEN-1:0]   pc_rdata_i;
    logic              smp_valid_o;
    logic              smp_ready_i;
    logic [4:0]        smp_idx_o;
    logic [63:0]       smp_data_o;
    logic [15:0]       drop_cnt_o;
    logic              busy_o;

    hpm_sample_ctrl #(
        .MHPMCounterNum (29),
        .NumCounters    (NCNT),
        .FifoDepth      (DEPTH),
        .XLEN           (XLEN)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cfg_en_i     (cfg_en_i),
        .cfg_period_i (cfg_period_i),
        .cfg_mask_i   (cfg_mask_i),
        .csr_req_i    (csr_req_i),
        .csr_addr_i   (csr_addr_i),
        .csr_we_i     (csr_we_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_gnt_o    (csr_gnt_o),
        .pc_addr_o    (pc_addr_o),
        .pc_we_o      (pc_we_o),
        .pc_wdata_o   (pc_wdata_o),
        .pc_rdata_i   (pc_rdata_i),
        .smp_valid_o  (smp_valid_o),
        .smp_ready_i  (smp_ready_i),
        .smp_idx_o    (smp_idx_o),
        .smp_data_o   (smp_data_o),
        .drop_cnt_o   (drop_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Free-running counter block; values start near a 32-bit carry so tears show up.
    logic [63:0] cnt [NCNT];

    always @(posedge clk) begin
        for (int k = 0; k < NCNT; k++) begin
            if (!rst_ni)
                cnt[k] <= 64'h0000_0000_FFFF_FFF8 + 64'(k * 5);
            else if (pc_we_o && pc_addr_o == 12'hB03 + 12'(k))
                cnt[k] <= {cnt[k][63:32], pc_wdata_o};
            else if (pc_we_o && pc_addr_o == 12'hB83 + 12'(k))
                cnt[k] <= {pc_wdata_o, cnt[k][31:0]};
            else
                cnt[k] <= cnt[k] + 64'd1;
        end
    end

    always_comb begin
        pc_rdata_i = {20'hBAD00, pc_addr_o};
        for (int k = 0; k < NCNT; k++) begin
            if (pc_addr_o == 12'hB03 + 12'(k)) pc_rdata_i = cnt[k][31:0];
            if (pc_addr_o == 12'hB83 + 12'(k)) pc_rdata_i = cnt[k][63:32];
        end
    end

    function automatic logic [31:0] ctr_read(input logic [11:0] a);
        logic [31:0] v;
        v = {20'hBAD00, a};
        for (int k = 0; k < NCNT; k++) begin
            if (a == 12'hB03 + 12'(k)) v = cnt[k][31:0];
            if (a == 12'hB83 + 12'(k)) v = cnt[k][63:32];
        end
        return v;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a scan is a list of steps (read low, read high, push) consumed one per free cycle.
    localparam int K_LO = 0, K_HI = 1, K_PUSH = 2, K_NONE = 3;
    int          step_kind [$];
    int          step_k    [$];
    int          wait_left;
    logic [63:0] m_val;
    int          m_cnt;
    int          m_drop;
    logic [68:0] exp_q [$];

    task automatic model_reset();
        step_kind.delete();
        step_k.delete();
        exp_q.delete();
        wait_left = 0;
        m_cnt     = 0;
        m_drop    = 0;
        m_val     = '0;
    endtask

    task automatic model_step();
        int  eff;
        bit  busy;
        bit  pop;
        bit  push;
        int  k;
        eff  = (cfg_period_i == 16'd0) ? 1 : int'(cfg_period_i);
        busy = (step_kind.size() != 0);
        pop  = (m_cnt > 0) && smp_ready_i;
        push = 1'b0;
        k    = busy ? step_k[0] : 0;
        chk("busy", busy_o, busy);
        chk("smp_valid", smp_valid_o, m_cnt > 0);
        chk("drop_cnt", drop_cnt_o, m_drop);
        if (csr_req_i) begin
            chk("csr_gnt", csr_gnt_o, 1);
            chk("csr_rdata", csr_rdata_o, ctr_read(csr_addr_i));
            chk("pc_addr_csr", pc_addr_o, csr_addr_i);
            chk("pc_we_csr", pc_we_o, csr_we_i);
            chk("pc_wdata_csr", pc_wdata_o, csr_wdata_i);
        end else begin
            chk("csr_gnt_idle", csr_gnt_o, 0);
            chk("csr_rdata_idle", csr_rdata_o, 0);
            chk("pc_we_idle", pc_we_o, 0);
            chk("pc_wdata_idle", pc_wdata_o, 0);
            if (busy && step_kind[0] == K_LO) chk("pc_addr_lo", pc_addr_o, 12'hB03 + 12'(k));
            if (busy && step_kind[0] == K_HI) chk("pc_addr_hi", pc_addr_o, 12'hB83 + 12'(k));
            if (busy) begin
                if (!cfg_en_i) begin
                    step_kind.delete();
                    step_k.delete();
                    wait_left = eff - 1;
                end else begin
                    case (step_kind[0])
                        K_LO:    m_val[31:0]  = cnt[k][31:0];
                        K_HI:    m_val[63:32] = cnt[k][63:32];
                        K_PUSH:  push = 1'b1;
                        default: ;
                    endcase
                    void'(step_kind.pop_front());
                    void'(step_k.pop_front());
                    if (step_kind.size() == 0) wait_left = eff - 1;
                end
            end else if (cfg_en_i) begin
                if (wait_left == 0) begin
                    for (int i = 0; i < NCNT; i++) begin
                        if (cfg_mask_i[i]) begin
                            step_kind.push_back(K_LO);   step_k.push_back(i);
                            if (XLEN == 32) begin
                                step_kind.push_back(K_HI); step_k.push_back(i);
                            end
                            step_kind.push_back(K_PUSH); step_k.push_back(i);
                        end
                    end
                    if (step_kind.size() == 0) begin
                        step_kind.push_back(K_NONE); step_k.push_back(0);
                    end
                end else begin
                    wait_left--;
                end
            end
        end
        if (push) begin
            if (m_cnt < DEPTH || pop) begin
                exp_q.push_back({5'(k + 3), m_val});
                m_cnt++;
            end else if (m_drop != 65535) begin
                m_drop++;
            end
        end
        if (pop) m_cnt--;
    endtask

    // Monitor: the head must match the oldest expected sample whenever valid.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_ni && smp_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", {59'd0, smp_idx_o}, 64'd0);
                end else begin
                    chk("smp_idx", smp_idx_o, exp_q[0][68:64]);
                    chk("smp_data", smp_data_o, exp_q[0][63:0]);
                    if (smp_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input int p_en, input int p_csr, input int p_rdy,
                         input int mask, input int period, input int chg);
        int sel;
        @(negedge clk);
        rst_ni      = 1'b1;
        cfg_en_i    = ($urandom_range(0, 99) < p_en);
        if (mask >= 0) cfg_mask_i = NCNT'(mask);
        else if ($urandom_range(0, 99) < chg) cfg_mask_i = NCNT'($urandom);
        if (period >= 0) cfg_period_i = 16'(period);
        else if ($urandom_range(0, 99) < chg) cfg_period_i = 16'($urandom_range(0, 6));
        csr_req_i   = ($urandom_range(0, 99) < p_csr);
        sel         = $urandom_range(0, 3);
        csr_addr_i  = (sel == 0) ? 12'hB83 + 12'($urandom_range(0, NCNT - 1)) :
                      (sel == 1) ? 12'h300 : 12'hB03 + 12'($urandom_range(0, NCNT - 1));
        csr_we_i    = ($urandom_range(0, 3) == 0);
        csr_wdata_i = $urandom;
        smp_ready_i = ($urandom_range(0, 99) < p_rdy);
        #1;
        model_step();
    endtask

    task automatic run_phase(input int n, input int p_en, input int p_csr, input int p_rdy,
                             input int mask, input int period, input int chg);
        for (int c = 0; c < n; c++) drive(p_en, p_csr, p_rdy, mask, period, chg);
    endtask

    task automatic check_reset_outputs();
        chk("rst_smp_valid", smp_valid_o, 0);
        chk("rst_smp_idx", smp_idx_o, 0);
        chk("rst_smp_data", smp_data_o, 0);
        chk("rst_drop_cnt", drop_cnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_csr_gnt", csr_gnt_o, 0);
        chk("rst_csr_rdata", csr_rdata_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_busy;
        rst_ni       = 1'b0;
        cfg_en_i     = 1'b0;
        cfg_period_i = 16'd0;
        cfg_mask_i   = '0;
        csr_req_i    = 1'b0;
        csr_addr_i   = '0;
        csr_we_i     = 1'b0;
        csr_wdata_i  = '0;
        smp_ready_i  = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset_outputs();
        end

        run_phase(300, 100,  0, 100, 6'b000101, 10, 0);
        run_phase(300, 100, 25, 100, 6'b000101,  4, 0);
        run_phase(200, 100,  0,   0, 6'b111111,  2, 0);
        run_phase(400, 100, 10,  50, 6'b111111,  0, 0);
        run_phase(200, 100,  0, 100, 6'b000000,  0, 0);
        run_phase(800,  92, 15,  60, -1, -1, 5);

        seen_busy = 1'b0;
        for (int c = 0; c < 200 && !seen_busy; c++) begin
            drive(100, 0, 50, 6'b110110, 1, 0);
            seen_busy = busy_o;
        end
        chk("busy_before_reset", seen_busy, 1);
        @(negedge clk);
        rst_ni    = 1'b0;
        csr_req_i = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();

        run_phase(600, 92, 15, 60, -1, -1, 5);
        run_phase(30, 0, 0, 100, -1, -1, 0);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hpm_sample_ctrl.md
HPM_SAMPLE_CTRL -- requirements
Module: hpm_sample_ctrl

Interface
REQ-001 SHALL have parameter NumCounters, default MHPMCounterNum: the number of HPM counters sampled (counter k=0 is mhpmcounter3).
REQ-002 SHALL have parameter FifoDepth, default 4: the sample FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-003 SHALL use one clock and an asynchronous active-low reset, as the following two ports.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 cfg_en_i  in  1  sampling enable.
REQ-007 cfg_period_i  in  16  cycles between scans; 0 is treated as 1.
REQ-008 cfg_mask_i  in  NumCounters  per-counter sample enable.
REQ-009 csr_req_i  in  1  CSR-file access request.
REQ-010 csr_addr_i  in  12  CSR address.
REQ-011 csr_we_i  in  1  CSR write enable.
REQ-012 csr_wdata_i  in  XLEN  CSR write data.
REQ-013 csr_rdata_o  out  XLEN  CSR read data.
REQ-014 csr_gnt_o  out  1  CSR access granted this cycle.
REQ-015 pc_addr_o  out  12  address to the counter block.
REQ-016 pc_we_o  out  1  write enable to the counter block.
REQ-017 pc_wdata_o  out  XLEN  write data to the counter block.
REQ-018 pc_rdata_i  in  XLEN  read data from the counter block; combinational from pc_addr_o, valid in the same cycle.
REQ-019 smp_valid_o  out  1  sample available at the FIFO head.
REQ-020 smp_ready_i  in  1  consumer accepts the sample.
REQ-021 smp_idx_o  out  5  counter number at the head (3..31).
REQ-022 smp_data_o  out  64  counter value at the head.
REQ-023 drop_cnt_o  out  16  samples dropped because the FIFO was full; saturating.
REQ-024 busy_o  out  1  a scan is in progress.

Function
REQ-025 Port ownership SHALL be decided each cycle.
- csr_req_i=1: pc_addr/we/wdata = the csr_* inputs; csr_rdata_o = pc_rdata_i; csr_gnt_o=1.
- Otherwise: the controller owns the port; pc_we_o=0, pc_wdata_o=0, csr_gnt_o=0, csr_rdata_o=0.
REQ-026 The controller SHALL NEVER assert pc_we_o.
REQ-027 The FSM SHALL have four states, with these transitions:
- WAIT to SCAN_LO when the timer is 0 and cfg_en_i=1.
- SCAN_LO to SCAN_HI when XLEN=32; to NEXT when XLEN=64.
- SCAN_HI to NEXT.
- NEXT to SCAN_LO for the next masked counter, or to WAIT when none remains.
REQ-028 The timer SHALL load cfg_period_i-1 on entry to WAIT and decrement once per cycle while cfg_en_i=1; it SHALL hold during a scan.
REQ-029 A scan SHALL visit counters k with cfg_mask_i[k]=1 in ascending order and skip counters with mask 0 at no cycle cost.
REQ-030 With mask all zero, a scan SHALL complete in one NEXT cycle and push nothing.
REQ-031 SCAN_LO SHALL drive pc_addr_o=CSR_MHPM_COUNTER_3+k and capture pc_rdata_i into bits [XLEN-1:0].
REQ-032 SCAN_HI SHALL drive CSR_MHPM_COUNTER_3H+k and capture bits [63:32]; a low/high tear is not corrected.
REQ-033 A cycle with csr_gnt_o=1 SHALL stall the FSM with no capture and no state change; the read is retried on the next free cycle.
REQ-034 NEXT SHALL push {k+3, value} into the FIFO if it is not full; if full, it SHALL drop the sample and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-035 A push and a pop in the same cycle on a full FIFO SHALL NOT drop the sample; the count stays unchanged.
REQ-036 The FIFO SHALL pop on smp_valid_o & smp_ready_i; the smp_* outputs SHALL be registered at the head and stable while valid & !ready.
REQ-037 cfg_en_i deasserted mid-scan SHALL abort to WAIT on the next edge; FIFO contents and drop_cnt_o are retained.
REQ-038 busy_o SHALL be 1 in SCAN_LO, SCAN_HI and NEXT.
REQ-039 cfg_period_i and cfg_mask_i SHALL be sampled at the start of a scan and on WAIT entry.

Reset
REQ-040 On rst_ni=0 the block SHALL reset asynchronously:
- FSM to WAIT, timer=0, FIFO empty.
- smp_valid_o=0, smp_idx_o=0, smp_data_o=0.
- drop_cnt_o=0, busy_o=0.
REQ-041 Reset asserted mid-scan SHALL discard the partial sample; the first scan SHALL start 1 cycle after rst_ni rises, provided cfg_en_i=1.

Verification
REQ-042 XLEN=64, NumCounters=6, period=10, mask=6'b000101, ready=1 -> each scan yields idx 3 then idx 5 with the values read; scans start 10+scan-length cycles apart.
REQ-043 csr_req_i held for 3 cycles during SCAN_LO -> csr_gnt_o=1 with correct csr_rdata_o; the sample is delayed 3 cycles; pc_we_o passes only the CSR write.
REQ-044 ready=0, FifoDepth=4, mask=6'b111111 -> 4 samples held; drop_cnt_o=2 after the first scan; the head is stable.
REQ-045 Full FIFO with ready=1 in the same cycle as a NEXT push -> no drop, and the FIFO stays at 4 entries.
REQ-046 XLEN=32, counter value 64'h1_0000_0005 -> smp_data_o=64'h1_0000_0005 after SCAN_LO then SCAN_HI reads of 0xB03 and 0xB83.
REQ-047 cfg_en_i=0 during SCAN_HI, then reset mid-scan -> abort to WAIT with no push; after reset all outputs are 0.
